// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a shared combinational ALU.
// Each operation goes through IDLE -> EXEC -> DONE, and the result is held until the consumer accepts it.
module alu_arbiter #(
    parameter int DSIZE = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic [3:0]       code0,
    input  logic [3:0]       code1,
    input  logic [DSIZE-1:0] a0,
    input  logic [DSIZE-1:0] b0,
    input  logic [DSIZE-1:0] imm0,
    input  logic [DSIZE-1:0] a1,
    input  logic [DSIZE-1:0] b1,
    input  logic [DSIZE-1:0] imm1,
    output logic             gnt0,
    output logic             gnt1,
    output logic [3:0]       alu_code,
    output logic [DSIZE-1:0] alu_a,
    output logic [DSIZE-1:0] alu_b,
    output logic [DSIZE-1:0] alu_imm,
    input  logic [DSIZE-1:0] alu_out,
    input  logic             alu_zero,
    output logic             rsp_valid,
    output logic             rsp_id,
    output logic [DSIZE-1:0] rsp_data,
    output logic             rsp_zero,
    input  logic             rsp_ready,
    output logic             busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic             prio_q, prio_d;
    logic             sel_q, sel_d;
    logic [3:0]       alu_code_q, alu_code_d;
    logic [DSIZE-1:0] alu_a_q, alu_a_d;
    logic [DSIZE-1:0] alu_b_q, alu_b_d;
    logic [DSIZE-1:0] alu_imm_q, alu_imm_d;
    logic             rsp_id_q, rsp_id_d;
    logic [DSIZE-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_zero_q, rsp_zero_d;

    logic winner;
    logic grant;

    // A lone request always wins; the priority pointer only breaks ties.
    assign winner = (req0 && req1) ? prio_q : req1;
    // The reset term keeps both grant strobes low while reset is asserted.
    assign grant  = (state_q == S_IDLE) && (req0 || req1) && rst;

    always_comb begin
        state_d    = state_q;
        prio_d     = prio_q;
        sel_d      = sel_q;
        alu_code_d = alu_code_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_imm_d  = alu_imm_q;
        rsp_id_d   = rsp_id_q;
        rsp_data_d = rsp_data_q;
        rsp_zero_d = rsp_zero_q;
        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    sel_d      = winner;
                    alu_code_d = winner ? code1 : code0;
                    alu_a_d    = winner ? a1    : a0;
                    alu_b_d    = winner ? b1    : b0;
                    alu_imm_d  = winner ? imm1  : imm0;
                    state_d    = S_EXEC;
                end
            end
            S_EXEC: begin
                rsp_data_d = alu_out;
                rsp_zero_d = alu_zero;
                rsp_id_d   = sel_q;
                state_d    = S_DONE;
            end
            S_DONE: begin
                if (rsp_ready) begin
                    prio_d  = ~sel_q;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            prio_q     <= 1'b0;
            sel_q      <= 1'b0;
            alu_code_q <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_imm_q  <= '0;
            rsp_id_q   <= 1'b0;
            rsp_data_q <= '0;
            rsp_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            prio_q     <= prio_d;
            sel_q      <= sel_d;
            alu_code_q <= alu_code_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_imm_q  <= alu_imm_d;
            rsp_id_q   <= rsp_id_d;
            rsp_data_q <= rsp_data_d;
            rsp_zero_q <= rsp_zero_d;
        end
    end

    assign gnt0      = grant && !winner;
    assign gnt1      = grant && winner;
    assign alu_code  = alu_code_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_imm   = alu_imm_q;
    assign rsp_valid = (state_q == S_DONE);
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_zero  = rsp_zero_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a vector table of single operations followed by
// hand-written backpressure, reset-in-flight and alternating-priority sequences.
module tb_alu_arbiter;
    localparam int DSIZE = 32;
    localparam logic [3:0] OP_ADD = 4'd0, OP_MUL = 4'd1, OP_ADDI = 4'd2,
                           OP_LW = 4'd3, OP_SW = 4'd4, OP_BNE = 4'd5;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0, req1;
    logic [3:0]       code0, code1;
    logic [DSIZE-1:0] a0, b0, imm0, a1, b1, imm1;
    logic             gnt0, gnt1;
    logic [3:0]       alu_code;
    logic [DSIZE-1:0] alu_a, alu_b, alu_imm, alu_out;
    logic             alu_zero;
    logic             rsp_valid, rsp_id, rsp_zero, rsp_ready, busy;
    logic [DSIZE-1:0] rsp_data;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.DSIZE(DSIZE)) dut (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1),
        .code0(code0), .code1(code1),
        .a0(a0), .b0(b0), .imm0(imm0), .a1(a1), .b1(b1), .imm1(imm1),
        .gnt0(gnt0), .gnt1(gnt1),
        .alu_code(alu_code), .alu_a(alu_a), .alu_b(alu_b), .alu_imm(alu_imm),
        .alu_out(alu_out), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_zero(rsp_zero),
        .rsp_ready(rsp_ready), .busy(busy)
    );

    // Shared combinational ALU as the arbiter sees it.
    always_comb begin
        case (alu_code)
            OP_ADD:               alu_out = alu_a + alu_b;
            OP_MUL:               alu_out = alu_a * alu_b;
            OP_ADDI, OP_LW, OP_SW: alu_out = alu_a + alu_imm;
            OP_BNE:               alu_out = alu_a - alu_b;
            default:              alu_out = '0;
        endcase
        alu_zero = (alu_out == '0);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        r0, r1;
        logic [3:0]  c0;
        logic [31:0] a0, b0, i0;
        logic [3:0]  c1;
        logic [31:0] a1, b1, i1;
        logic        eid;
        logic [31:0] edata;
        logic        ezero;
    } vec_t;

    vec_t vecs[8];

    initial begin
        // Expected winners assume prio starts at 0 after reset and flips to the
        // requester not served after every accepted response.
        vecs[0] = '{1,0, OP_ADD, 5, 7, 0,                OP_ADD, 0, 0, 0,   0, 12, 0};
        vecs[1] = '{0,1, OP_ADD, 0, 0, 0,                OP_BNE, 9, 9, 0,   1, 0,  1};
        vecs[2] = '{1,1, OP_MUL, 3, 4, 0,                OP_ADD, 1, 2, 0,   0, 12, 0};
        vecs[3] = '{1,1, OP_MUL, 3, 4, 0,                OP_ADD, 1, 2, 0,   1, 3,  0};
        vecs[4] = '{1,0, OP_ADDI, 32'hFFFF_FFFF, 0, 1,   OP_ADD, 0, 0, 0,   0, 0,  1};
        vecs[5] = '{1,0, OP_MUL, 32'h1_0000, 32'h1_0000, 0, OP_ADD, 0, 0, 0, 0, 0, 1};
        vecs[6] = '{1,1, OP_ADD, 1, 1, 0,                OP_MUL, 6, 7, 0,   1, 42, 0};
        vecs[7] = '{0,1, OP_ADD, 0, 0, 0,                OP_LW, 100, 0, 4,  1, 104, 0};
    end

    initial begin
        logic [31:0] last_a;
        int gcount, last_cyc, cyc;

        rst = 1'b0; req0 = 0; req1 = 0; rsp_ready = 1;
        code0 = 0; code1 = 0; a0 = 0; b0 = 0; imm0 = 0; a1 = 0; b1 = 0; imm1 = 0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_busy", 32'(busy), 0);
        chk("reset_rsp_valid", 32'(rsp_valid), 0);
        chk("reset_alu_a", alu_a, 0);
        chk("reset_rsp_data", rsp_data, 0);
        @(negedge clk);
        rst = 1'b1;

        // ---------------- vector table ----------------
        last_a = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #1;
            chk("idle_busy", 32'(busy), 0);
            chk("idle_rsp_valid", 32'(rsp_valid), 0);
            chk("idle_alu_a_held", alu_a, last_a);
            req0 = vecs[i].r0; req1 = vecs[i].r1;
            code0 = vecs[i].c0; a0 = vecs[i].a0; b0 = vecs[i].b0; imm0 = vecs[i].i0;
            code1 = vecs[i].c1; a1 = vecs[i].a1; b1 = vecs[i].b1; imm1 = vecs[i].i1;
            rsp_ready = 1;
            #1;
            chk("gnt0", 32'(gnt0), 32'(!vecs[i].eid));
            chk("gnt1", 32'(gnt1), 32'(vecs[i].eid));
            @(negedge clk);
            req0 = 0; req1 = 0;
            a0 = 32'hDEAD; a1 = 32'hBEEF;
            #1;
            chk("exec_busy", 32'(busy), 1);
            chk("exec_rsp_valid", 32'(rsp_valid), 0);
            chk("exec_gnt", 32'({gnt0, gnt1}), 0);
            chk("exec_alu_code", 32'(alu_code), 32'(vecs[i].eid ? vecs[i].c1 : vecs[i].c0));
            chk("exec_alu_a", alu_a, vecs[i].eid ? vecs[i].a1 : vecs[i].a0);
            chk("exec_alu_b", alu_b, vecs[i].eid ? vecs[i].b1 : vecs[i].b0);
            chk("exec_alu_imm", alu_imm, vecs[i].eid ? vecs[i].i1 : vecs[i].i0);
            last_a = vecs[i].eid ? vecs[i].a1 : vecs[i].a0;
            @(negedge clk);
            #1;
            chk("done_rsp_valid", 32'(rsp_valid), 1);
            chk("done_rsp_id", 32'(rsp_id), 32'(vecs[i].eid));
            chk("done_rsp_data", rsp_data, vecs[i].edata);
            chk("done_rsp_zero", 32'(rsp_zero), 32'(vecs[i].ezero));
            $display("vec %0d: id=%0d data=0x%08h zero=%0d", i, rsp_id, rsp_data, rsp_zero);
        end
        // Last vector served requester 1, so prio now favours requester 0.

        // ---------------- backpressure ----------------
        @(negedge clk);
        req0 = 1; code0 = OP_ADD; a0 = 2; b0 = 3; rsp_ready = 0;
        #1;
        chk("bp_gnt0", 32'(gnt0), 1);
        @(negedge clk);
        req0 = 0; req1 = 1; code1 = OP_ADD; a1 = 1; b1 = 1; imm1 = 0;
        @(negedge clk);
        #1;
        chk("bp_done_valid", 32'(rsp_valid), 1);
        chk("bp_done_data", rsp_data, 5);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            chk("bp_hold_valid", 32'(rsp_valid), 1);
            chk("bp_hold_data", rsp_data, 5);
            chk("bp_hold_id", 32'(rsp_id), 0);
            chk("bp_hold_gnt", 32'({gnt0, gnt1}), 0);
            chk("bp_hold_busy", 32'(busy), 1);
        end
        rsp_ready = 1;
        #1;
        chk("bp_accept_no_gnt", 32'({gnt0, gnt1}), 0);
        @(negedge clk);
        #1;
        chk("bp_idle_busy", 32'(busy), 0);
        chk("bp_idle_valid", 32'(rsp_valid), 0);
        chk("bp_next_gnt1", 32'(gnt1), 1);
        @(negedge clk);
        req1 = 0;
        @(negedge clk);
        #1;
        chk("bp_next_id", 32'(rsp_id), 1);
        chk("bp_next_data", rsp_data, 2);
        $display("backpressure: held 5 cycles, next id=%0d data=%0d", rsp_id, rsp_data);

        // ---------------- reset during EXEC ----------------
        @(negedge clk);
        req1 = 1; code1 = OP_MUL; a1 = 3; b1 = 4; imm1 = 9;
        #1;
        chk("rst_gnt1", 32'(gnt1), 1);
        @(negedge clk);
        #1;
        chk("rst_exec_busy", 32'(busy), 1);
        rst = 0;
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_valid", 32'(rsp_valid), 0);
        chk("rst_gnt", 32'({gnt0, gnt1}), 0);
        chk("rst_alu_code", 32'(alu_code), 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_alu_imm", alu_imm, 0);
        chk("rst_rsp_id", 32'(rsp_id), 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_zero", 32'(rsp_zero), 0);
        @(negedge clk);
        #1;
        chk("rst_hold_valid", 32'(rsp_valid), 0);
        rst = 1;
        #1;
        chk("rst_regrant", 32'(gnt1), 1);
        @(negedge clk);
        req1 = 0;
        #1;
        chk("rst_regrant_valid", 32'(rsp_valid), 0);
        @(negedge clk);
        #1;
        chk("rst_regrant_rsp_valid", 32'(rsp_valid), 1);
        chk("rst_regrant_id", 32'(rsp_id), 1);
        chk("rst_regrant_data", rsp_data, 12);
        $display("reset in EXEC: regrant id=%0d data=%0d", rsp_id, rsp_data);

        // ---------------- alternation after reset ----------------
        @(negedge clk);
        rst = 0;
        req0 = 1; req1 = 1;
        code0 = OP_ADD; a0 = 10; b0 = 1; code1 = OP_ADD; a1 = 20; b1 = 2;
        @(negedge clk);
        rst = 1;
        #1;
        gcount = 0; last_cyc = 0; cyc = 0;
        while (gcount < 4 && cyc < 30) begin
            if (gnt0 && gnt1) chk("alt_both_gnt", 32'({gnt0, gnt1}), 32'b10);
            if (gnt0 || gnt1) begin
                chk("alt_order", 32'(gnt1), 32'(gcount % 2));
                if (gcount > 0) chk("alt_spacing", 32'(cyc - last_cyc), 3);
                $display("alt grant %0d: requester %0d at cycle %0d", gcount, gnt1, cyc);
                last_cyc = cyc;
                gcount++;
            end
            @(negedge clk);
            #1;
            cyc++;
        end
        chk("alt_grant_count", 32'(gcount), 4);
        req0 = 0; req1 = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
